pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Fetch sequencer for the program-counter register: it decides, every cycle, which `pc_op`/`target_addr` pair the PC applies. It owns the instruction-memory request handshake and arbitrates trap, jump and branch redirects. It drains an in-flight fetch before redirecting and signals the pipeline to flush. It sits between the decode/execute redirect sources and the PC block, whose `pc_op` encoding it drives directly.

## Interface
- `TRAP_VEC`, 32'h0000_0100, absolute trap target address
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stall`  in  1  downstream cannot accept further instructions
- `trap_req`  in  1  trap redirect pulse
- `jump_req`  in  1  jump redirect pulse
- `jump_addr`  in  32  absolute jump target
- `branch_req`  in  1  taken-branch redirect pulse
- `branch_off`  in  32  signed byte offset relative to current PC
- `imem_req`  out  1  fetch request at current PC
- `imem_ack`  in  1  fetch complete, instruction available this cycle
- `fetch_valid`  out  1  current ack carries a usable instruction
- `flush`  out  1  kill younger in-flight instructions
- `pc_op`  out  2  00 increment by 4, 01 load target_addr, 10 add signed target_addr, 11 hold
- `target_addr`  out  32  jump target or branch offset for PC

## Operation
- Redirect priority when several requests are high in one cycle: trap > jump > branch. Only the winner is captured into `pend_op`/`pend_addr`; losers are dropped.
- Capture mapping:
  - trap → (01, `TRAP_VEC`)
  - jump → (01, `jump_addr`)
  - branch → (10, `branch_off`)
- A capture in DRAIN overwrites the pending redirect. Last accepted winner is issued.
- `flush`=1 in exactly the cycle a redirect is captured. It is combinational on the request inputs in any state.
- FSM states BOOT, FETCH, DRAIN, REDIRECT, STALL:
  - **BOOT:** entered on reset. `imem_req`=0, `pc_op`=11. Redirect → REDIRECT; otherwise → FETCH.
  - **FETCH:** `imem_req`=1.
    - Redirect with `imem_ack`: `fetch_valid`=0, `pc_op`=11 → REDIRECT.
    - Redirect without ack: `pc_op`=11 → DRAIN.
    - Ack with no redirect: `fetch_valid`=1, `pc_op`=00. Then → STALL if `stall`, else stay FETCH.
    - No ack: `pc_op`=11.
  - **DRAIN:** `imem_req` held 1, `pc_op`=11. On `imem_ack`: `fetch_valid`=0 (discarded) → REDIRECT.
  - **REDIRECT:** `imem_req`=0, `pc_op`=`pend_op`, `target_addr`=`pend_addr`. A new redirect this cycle is captured and the state stays REDIRECT. Otherwise → STALL if `stall`, else FETCH.
  - **STALL:** `imem_req`=0, `pc_op`=11. Redirect → REDIRECT; `stall`=0 → FETCH.
- `imem_req` never drops while a fetch is outstanding, i.e. before `imem_ack`.
- `imem_ack` outside FETCH/DRAIN is ignored (bench asserts it never occurs).
- `target_addr` is 0 whenever `pc_op` ≠ 01/10.
- Branch offset is passed through unmodified; sign handling is the PC block's job.

## Timing
- Reset values: state BOOT, `pend_op`=11, `pend_addr`=0. All outputs are 0, except `pc_op`=11.
- A `rst` asserted mid-fetch abandons the outstanding request; no drain occurs.
- Outputs are combinational from state, pending registers and current inputs. No input-to-output path through `imem_ack` other than `fetch_valid` and `pc_op`.
- Redirect latency:
  - From FETCH-with-ack, STALL, BOOT or REDIRECT: pulse in cycle N, PC-update `pc_op` in N+1, PC holds target after edge N+1, first fetch at target in N+2.
  - From FETCH without ack: the issue is delayed until the cycle after `imem_ack`.
- Sequential throughput: one instruction per cycle when `imem_ack` returns in the request cycle.

## Structure
- Shared package `pc_pkg`:
  - `pc_op` encoding constants `PC_INC`, `PC_JMP`, `PC_BR`, `PC_HOLD`
  - FSM state enum
  - Redirect-source priority encoding
- Single module, no sub-modules. The priority encoder is an in-module function.

## Test plan
- **Reset then sequential fetch:** release `rst`, `imem_ack` tied 1 → BOOT one cycle, then `pc_op`=00 and `fetch_valid`=1 every cycle; PC reads 0,4,8,12.
- **Jump with immediate ack:** `jump_req` with `jump_addr`=0x200 while ack=1 → `flush`=1 that cycle, `fetch_valid`=0, then `pc_op`=01 and `target_addr`=0x200; next fetch at PC 0x200.
- **Redirect during outstanding fetch:** ack delayed 3 cycles, `branch_req` with `branch_off`=-8 at PC 0x40 → DRAIN, `imem_req` held; on ack `fetch_valid`=0; then `pc_op`=10 and `target_addr`=0xFFFF_FFF8; PC becomes 0x38.
- **Simultaneous requests:** `trap_req`, `jump_req`, `branch_req` all high → `pc_op`=01 with `target_addr`=0x100; jump and branch are dropped.
- **Stall:** `stall`=1 on an acked fetch → `pc_op`=00 once, then STALL with `imem_req`=0 and `pc_op`=11 until `stall`=0; then fetch resumes at PC+4. A jump during STALL is issued next cycle.
- **Reset mid-DRAIN:** `rst` while a fetch is outstanding → next cycle BOOT, `imem_req`=0, `pc_op`=11, pending cleared, PC=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings for the fetch sequencer: PC operation codes, FSM states and
// redirect-source priority levels.
package pc_pkg;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_JMP  = 2'b01;
  localparam logic [1:0] PC_BR   = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StDrain,
    StRedirect,
    StStall
  } state_e;

  // Ordered so that a higher value wins arbitration.
  typedef enum logic [1:0] {
    SrcNone,
    SrcBranch,
    SrcJump,
    SrcTrap
  } src_e;

endpackage

// File: rtl/pc_ctrl.sv
// Fetch sequencer: drives pc_op/target_addr, owns the imem request handshake and
// arbitrates trap > jump > branch redirects, draining any outstanding fetch first.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        trap_req,
  input  logic        jump_req,
  input  logic [31:0] jump_addr,
  input  logic        branch_req,
  input  logic [31:0] branch_off,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        fetch_valid,
  output logic        flush,
  output logic [1:0]  pc_op,
  output logic [31:0] target_addr
);

  function automatic src_e pick_src(input logic trap, input logic jump, input logic branch);
    if (trap)        return SrcTrap;
    else if (jump)   return SrcJump;
    else if (branch) return SrcBranch;
    else             return SrcNone;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  pend_op_q, pend_op_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  src_e        src;
  logic        redirect;

  always_comb begin
    src         = pick_src(trap_req, jump_req, branch_req);
    redirect    = (src != SrcNone);
    pend_op_d   = pend_op_q;
    pend_addr_d = pend_addr_q;
    // Capture happens in every state; the latest winner overwrites any pending one.
    unique case (src)
      SrcTrap: begin
        pend_op_d   = PC_JMP;
        pend_addr_d = TRAP_VEC;
      end
      SrcJump: begin
        pend_op_d   = PC_JMP;
        pend_addr_d = jump_addr;
      end
      SrcBranch: begin
        pend_op_d   = PC_BR;
        pend_addr_d = branch_off;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    pc_op       = PC_HOLD;
    flush       = redirect;
    unique case (state_q)
      StBoot: begin
        state_d = redirect ? StRedirect : StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (redirect) begin
          state_d = imem_ack ? StRedirect : StDrain;
        end else if (imem_ack) begin
          fetch_valid = 1'b1;
          pc_op       = PC_INC;
          state_d     = stall ? StStall : StFetch;
        end
      end
      StDrain: begin
        // Hold the request until the outstanding fetch returns; its data is discarded.
        imem_req = 1'b1;
        if (imem_ack) state_d = StRedirect;
      end
      StRedirect: begin
        pc_op = pend_op_q;
        if (redirect)   state_d = StRedirect;
        else if (stall) state_d = StStall;
        else            state_d = StFetch;
      end
      StStall: begin
        if (redirect)    state_d = StRedirect;
        else if (!stall) state_d = StFetch;
      end
      default: state_d = StBoot;
    endcase
    target_addr = (pc_op == PC_JMP || pc_op == PC_BR) ? pend_addr_q : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBoot;
      pend_op_q   <= PC_HOLD;
      pend_addr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pend_op_q   <= pend_op_d;
      pend_addr_q <= pend_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl with a small PC register model driven by pc_op/target_addr.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        trap_req;
  logic        jump_req;
  logic [31:0] jump_addr;
  logic        branch_req;
  logic [31:0] branch_off;
  logic        imem_req;
  logic        imem_ack;
  logic        fetch_valid;
  logic        flush;
  logic [1:0]  pc_op;
  logic [31:0] target_addr;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  pc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .trap_req    (trap_req),
    .jump_req    (jump_req),
    .jump_addr   (jump_addr),
    .branch_req  (branch_req),
    .branch_off  (branch_off),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .pc_op       (pc_op),
    .target_addr (target_addr)
  );

  always #5 clk = ~clk;

  // The PC block this sequencer feeds.
  always_ff @(posedge clk) begin
    if (rst) pc <= 32'h0;
    else begin
      case (pc_op)
        2'b00:   pc <= pc + 32'd4;
        2'b01:   pc <= target_addr;
        2'b10:   pc <= pc + target_addr;
        default: pc <= pc;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are already applied; sample at the falling edge, then advance one cycle.
  task automatic step(input string tag, input logic req, input logic fv, input logic fl,
                      input logic [1:0] op, input logic [31:0] tgt, input logic [31:0] exp_pc);
    #4;
    chk({tag, ".imem_req"}, {31'h0, imem_req}, {31'h0, req});
    chk({tag, ".fetch_valid"}, {31'h0, fetch_valid}, {31'h0, fv});
    chk({tag, ".flush"}, {31'h0, flush}, {31'h0, fl});
    chk({tag, ".pc_op"}, {30'h0, pc_op}, {30'h0, op});
    chk({tag, ".target_addr"}, target_addr, tgt);
    chk({tag, ".pc"}, pc, exp_pc);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic ack, input logic t, input logic j,
                        input logic [31:0] ja, input logic b, input logic [31:0] bo);
    stall      = s;
    imem_ack   = ack;
    trap_req   = t;
    jump_req   = j;
    jump_addr  = ja;
    branch_req = b;
    branch_off = bo;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1;
    step("reset", 0, 0, 0, 2'b11, 32'h0, 32'h0);

    // Sequential fetch with ack tied high
    rst = 1'b0;
    set_in(0, 1, 0, 0, 32'h0, 0, 32'h0);
    step("boot", 0, 0, 0, 2'b11, 32'h0, 32'h0);
    step("seq0", 1, 1, 0, 2'b00, 32'h0, 32'h0);
    step("seq4", 1, 1, 0, 2'b00, 32'h0, 32'h4);
    step("seq8", 1, 1, 0, 2'b00, 32'h0, 32'h8);
    step("seq12", 1, 1, 0, 2'b00, 32'h0, 32'hC);

    // Jump with immediate ack
    set_in(0, 1, 0, 1, 32'h200, 0, 32'h0);
    step("jmp_cap", 1, 0, 1, 2'b11, 32'h0, 32'h10);
    set_in(0, 0, 0, 0, 32'h0, 0, 32'h0);
    step("jmp_iss", 0, 0, 0, 2'b01, 32'h200, 32'h10);
    set_in(0, 1, 0, 0, 32'h0, 0, 32'h0);
    step("jmp_fetch", 1, 1, 0, 2'b00, 32'h0, 32'h200);

    // Move to PC 0x40, then branch -8 while the fetch is outstanding
    set_in(0, 1, 0, 1, 32'h40, 0, 32'h0);
    step("j40_cap", 1, 0, 1, 2'b11, 32'h0, 32'h204);
    set_in(0, 0, 0, 0, 32'h0, 0, 32'h0);
    step("j40_iss", 0, 0, 0, 2'b01, 32'h40, 32'h204);
    set_in(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFF8);
    step("br_cap", 1, 0, 1, 2'b11, 32'h0, 32'h40);
    set_in(0, 0, 0, 0, 32'h0, 0, 32'h0);
    step("drain1", 1, 0, 0, 2'b11, 32'h0, 32'h40);
    step("drain2", 1, 0, 0, 2'b11, 32'h0, 32'h40);
    set_in(0, 1, 0, 0, 32'h0, 0, 32'h0);
    step("drain_ack", 1, 0, 0, 2'b11, 32'h0, 32'h40);
    set_in(0, 0, 0, 0, 32'h0, 0, 32'h0);
    step("br_iss", 0, 0, 0, 2'b10, 32'hFFFF_FFF8, 32'h40);
    set_in(0, 1, 0, 0, 32'h0, 0, 32'h0);
    step("br_fetch", 1, 1, 0, 2'b00, 32'h0, 32'h38);

    // Simultaneous trap, jump and branch: trap wins
    set_in(0, 1, 1, 1, 32'h300, 1, 32'h10);
    step("all_cap", 1, 0, 1, 2'b11, 32'h0, 32'h3C);
    set_in(0, 0, 0, 0, 32'h0, 0, 32'h0);
    step("trap_iss", 0, 0, 0, 2'b01, 32'h100, 32'h3C);
    set_in(0, 1, 0, 0, 32'h0, 0, 32'h0);
    step("trap_fetch", 1, 1, 0, 2'b00, 32'h0, 32'h100);

    // Stall on an acked fetch
    set_in(1, 1, 0, 0, 32'h0, 0, 32'h0);
    step("stall_ack", 1, 1, 0, 2'b00, 32'h0, 32'h104);
    set_in(1, 0, 0, 0, 32'h0, 0, 32'h0);
    step("stall1", 0, 0, 0, 2'b11, 32'h0, 32'h108);
    step("stall2", 0, 0, 0, 2'b11, 32'h0, 32'h108);
    set_in(0, 0, 0, 0, 32'h0, 0, 32'h0);
    step("stall_rel", 0, 0, 0, 2'b11, 32'h0, 32'h108);
    set_in(0, 1, 0, 0, 32'h0, 0, 32'h0);
    step("resume", 1, 1, 0, 2'b00, 32'h0, 32'h108);

    // Jump taken while stalled
    set_in(1, 1, 0, 0, 32'h0, 0, 32'h0);
    step("stall_ack2", 1, 1, 0, 2'b00, 32'h0, 32'h10C);
    set_in(1, 0, 0, 1, 32'h500, 0, 32'h0);
    step("stall_jmp", 0, 0, 1, 2'b11, 32'h0, 32'h110);
    set_in(0, 0, 0, 0, 32'h0, 0, 32'h0);
    step("stall_jiss", 0, 0, 0, 2'b01, 32'h500, 32'h110);
    set_in(0, 1, 0, 0, 32'h0, 0, 32'h0);
    step("j500_fetch", 1, 1, 0, 2'b00, 32'h0, 32'h500);

    // Reset while draining
    set_in(0, 0, 0, 0, 32'h0, 1, 32'h8);
    step("br2_cap", 1, 0, 1, 2'b11, 32'h0, 32'h504);
    set_in(0, 0, 0, 0, 32'h0, 0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("rst_boot", 0, 0, 0, 2'b11, 32'h0, 32'h0);
    set_in(0, 1, 0, 0, 32'h0, 0, 32'h0);
    step("rst_fetch", 1, 1, 0, 2'b00, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
